// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types and sizing helper for the ccff chain loader
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bitstream words needed to cover the chain; the last one may be partial.
  function automatic int unsigned words_needed(input int unsigned chain_len,
                                               input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - holds one bitstream word and presents it MSB-first to the chain head
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              room_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              shift_o,
  output logic              head_o
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              have_q, have_d;
  logic              last_bit;
  logic              accept;

  assign last_bit = (idx_q == IDX_LAST);
  assign shift_o  = enable_i && have_q;
  // A new word may land on the same edge the current word's last bit leaves.
  assign ready_o  = enable_i && room_i && (!have_q || (shift_o && last_bit));
  assign accept   = valid_i && ready_o;
  assign head_o   = word_q[IDX_LAST - idx_q];

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    have_d = have_q;
    if (clear_i) begin
      have_d = 1'b0;
      idx_d  = '0;
    end else if (accept) begin
      word_d = data_i;
      have_d = 1'b1;
      idx_d  = '0;
    end else if (shift_o) begin
      if (last_bit) begin
        have_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
      have_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      have_q <= have_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - loads one ccff chain from a word stream and accumulates tail readback parity
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_shifted,
  output logic              readback_parity
);

  localparam int WORDS = int'(words_needed(CHAIN_LEN, WORD_W));
  localparam int WL_W  = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WL_W-1:0]  WORDS_INIT = WL_W'(WORDS);

  state_e           state_q, state_d;
  logic [WL_W-1:0]  words_left_q, words_left_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic             parity_q, parity_d;
  logic             in_load;
  logic             load_go;
  logic             finish;
  logic             accept;
  logic             ser_clear;

  assign in_load = (state_q == ST_LOAD);
  assign accept  = cfg_valid && cfg_ready;
  assign finish  = in_load && ccff_shift_en && (bits_q == LAST_SHIFT);
  assign load_go = start && !abort && !in_load;
  // Dropping the held word on finish discards the unused LSBs of a partial last word.
  assign ser_clear = abort || load_go || finish;

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk_i    (prog_clk),
    .rst_i    (pReset),
    .clear_i  (ser_clear),
    .enable_i (in_load),
    .room_i   (words_left_q != '0),
    .data_i   (cfg_data),
    .valid_i  (cfg_valid),
    .ready_o  (cfg_ready),
    .shift_o  (ccff_shift_en),
    .head_o   (ccff_head)
  );

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    bits_d       = bits_q;
    parity_d     = parity_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (load_go) begin
      state_d      = ST_LOAD;
      words_left_d = WORDS_INIT;
      bits_d       = '0;
      parity_d     = 1'b0;
    end else if (in_load) begin
      if (accept) begin
        words_left_d = words_left_q - WL_W'(1);
      end
      if (ccff_shift_en) begin
        bits_d   = bits_q + CNT_W'(1);
        parity_d = parity_q ^ ccff_tail;
      end
      if (finish) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      bits_q       <= '0;
      parity_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      bits_q       <= bits_d;
      parity_q     <= parity_d;
    end
  end

  assign busy            = in_load;
  assign done            = (state_q == ST_DONE);
  assign bits_shifted    = bits_q;
  assign readback_parity = parity_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed and randomized loads checked against a bitstream-level model
module tb_ccff_chain_loader;

  localparam int W  = 8;
  localparam int L  = 20;
  localparam int NW = (L + W - 1) / W;
  localparam int CW = $clog2(L + 1);

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b0;
  logic          start;
  logic          abort;
  logic [W-1:0]  cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] bits_shifted;
  logic          readback_parity;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(
    .WORD_W    (W),
    .CHAIN_LEN (L)
  ) dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .start           (start),
    .abort           (abort),
    .cfg_data        (cfg_data),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .ccff_head       (ccff_head),
    .ccff_shift_en   (ccff_shift_en),
    .ccff_tail       (ccff_tail),
    .busy            (busy),
    .done            (done),
    .bits_shifted    (bits_shifted),
    .readback_parity (readback_parity)
  );

  // Model of upstream source and of the chain itself.
  logic [W-1:0] words [NW+1];
  logic [L-1:0] tail_pat;
  logic [L-1:0] head_rec;
  int  widx, accepts, gap_word, gap_left;
  int  nshift, run, max_run, low_mid, gap_bits;
  bit  feed_en;
  int  n_assert, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] exp_stream();
    logic [L-1:0] s;
    s = '0;
    for (int k = 0; k < L; k++) s[L-1-k] = words[k / W][W-1-(k % W)];
    return s;
  endfunction

  task automatic new_load(input logic [L-1:0] tail, input int gw, input int gl);
    tail_pat = tail;
    gap_word = gw;
    gap_left = gl;
    widx = 0; accepts = 0; nshift = 0; head_rec = '0;
    run = 0; max_run = 0; low_mid = 0; gap_bits = -1;
    feed_en = 1'b1;
  endtask

  task automatic rand_words();
    for (int i = 0; i <= NW; i++) words[i] = W'($urandom);
  endtask

  task automatic cycle();
    @(negedge prog_clk);
    #1;
    if (feed_en && widx <= NW) begin
      cfg_data  = words[widx];
      cfg_valid = !(widx == gap_word && gap_left > 0);
      if (!cfg_valid && cfg_ready) gap_left--;
      if (cfg_valid && cfg_ready) begin
        widx++;
        accepts++;
      end
    end else begin
      cfg_valid = 1'b0;
    end
    if (ccff_shift_en) begin
      if (nshift < L) begin
        head_rec[L-1-nshift] = ccff_head;
        ccff_tail = tail_pat[L-1-nshift];
      end
      nshift++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
      if (nshift > 0 && nshift < L) begin
        low_mid++;
        gap_bits = int'(bits_shifted);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) cycle();
    check({tag, "_done"}, done, 1);
  endtask

  task automatic verify_load(input string tag);
    check({tag, "_accepts"}, accepts, NW);
    check({tag, "_nshift"}, nshift, L);
    check({tag, "_stream"}, head_rec, exp_stream());
    check({tag, "_bits"}, bits_shifted, L);
    check({tag, "_parity"}, readback_parity, $countones(tail_pat) % 2);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_shift_off"}, ccff_shift_en, 0);
    check({tag, "_ready_off"}, cfg_ready, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, cfg_ready, 0);
    check({tag, "_shift"}, ccff_shift_en, 0);
    check({tag, "_head"}, ccff_head, 0);
    check({tag, "_bits"}, bits_shifted, 0);
    check({tag, "_parity"}, readback_parity, 0);
  endtask

  initial begin
    int gw, gl;
    n_assert = 0; n_fail = 0;
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0; ccff_tail = 1'b0;
    feed_en = 1'b0; widx = 0; gap_word = -1; gap_left = 0;
    #2 pReset = 1'b1;
    repeat (2) @(negedge prog_clk);
    #1;
    check_all_zero("reset");
    pReset = 1'b0;
    cycle();

    // Directed: A5,3C,F0 always valid, tail with seven ones.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h5A;
    new_load(20'h07F00, -1, 0);
    pulse_start();
    check("t1_busy", busy, 1);
    run_to_done("t1", 100);
    verify_load("t1");
    check("t1_run", max_run, L);
    repeat (3) cycle();
    check("t1_hold_done", done, 1);
    check("t1_hold_bits", bits_shifted, L);
    check("t1_no_more_words", accepts, NW);

    // Reload from DONE, same words, 5-cycle valid gap after word 1, zero tail.
    new_load(20'h00000, 1, 5);
    pulse_start();
    check("t2_done_fell", done, 0);
    check("t2_busy_rose", busy, 1);
    run_to_done("t2", 100);
    verify_load("t2");
    check("t2_gap_cycles", low_mid, 5);
    check("t2_gap_bits", gap_bits, 8);

    // start while loading must not restart the load.
    rand_words();
    new_load(L'($urandom), -1, 0);
    pulse_start();
    repeat (6) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("t3_still_busy", busy, 1);
    run_to_done("t3", 100);
    verify_load("t3");

    // Abort after 11 shifts, then a clean reload.
    rand_words();
    new_load(L'($urandom), -1, 0);
    pulse_start();
    for (int i = 0; i < 100 && bits_shifted != CW'(11); i++) cycle();
    check("t4_reached_11", bits_shifted, 11);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t4_idle_busy", busy, 0);
    check("t4_idle_done", done, 0);
    check("t4_idle_shift", ccff_shift_en, 0);
    check("t4_idle_ready", cfg_ready, 0);
    rand_words();
    new_load(L'($urandom), -1, 0);
    pulse_start();
    check("t4_restart_bits", bits_shifted, 0);
    check("t4_restart_busy", busy, 1);
    run_to_done("t4r", 100);
    verify_load("t4r");

    // Asynchronous reset in the middle of the second word.
    rand_words();
    new_load(L'($urandom), -1, 0);
    pulse_start();
    for (int i = 0; i < 100 && nshift < 12; i++) cycle();
    #2 pReset = 1'b1;
    #1;
    check_all_zero("t5_async");
    @(negedge prog_clk);
    #1 pReset = 1'b0;
    rand_words();
    new_load(L'($urandom), -1, 0);
    pulse_start();
    run_to_done("t5r", 100);
    verify_load("t5r");

    // Randomized loads with a random valid gap.
    for (int it = 0; it < 5; it++) begin
      rand_words();
      gw = int'($urandom_range(0, NW));
      gl = int'($urandom_range(0, 6));
      new_load(L'($urandom), gw, gl);
      pulse_start();
      run_to_done($sformatf("r%0d", it), 150);
      verify_load($sformatf("r%0d", it));
      check($sformatf("r%0d_gap", it), low_mid, (gw >= 1 && gw < NW) ? gl : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
